ryuki_mem_arbiter: RTL and testbench
====================================

// Module: ryuki_mem_arbiter
// PURPOSE
//   Shares one unified req/gnt/rvalid memory port between the core instruction port and data port.
//   Sits between riscv_core and a single memory; trace_unit keeps observing the core-side signals unchanged.
//   Round-robin (or fixed data-first) arbitration, address held stable until grant, in-order response routing
//   via an outstanding-transaction FIFO.
// PARAMETERS
//   ADDR_WIDTH       32  address width, all ports
//   DATA_WIDTH       32  data width; byte enable width = DATA_WIDTH/8
//   MAX_OUTSTANDING  2   granted-but-unanswered transactions allowed (>=1)
//   FIXED_PRIO       0   0: round-robin on ties; 1: data port always wins ties
// PORTS
//   clk_i            in   1    clock
//   rst_i            in   1    reset, synchronous, active-high
//   instr_req_i      in   1    instr request
//   instr_addr_i     in   AW   instr address
//   instr_gnt_o      out  1    instr request accepted
//   instr_rvalid_o   out  1    instr read data valid
//   instr_rdata_o    out  DW   instr read data
//   data_req_i       in   1    data request
//   data_addr_i      in   AW   data address
//   data_we_i        in   1    data write enable
//   data_be_i        in   DW/8 data byte enables
//   data_wdata_i     in   DW   data write data
//   data_gnt_o       out  1    data request accepted
//   data_rvalid_o    out  1    data response valid (reads and writes)
//   data_rdata_o     out  DW   data read data
//   data_err_o       out  1    data bus error, valid with data_rvalid_o
//   mem_req_o        out  1    memory request
//   mem_addr_o       out  AW   memory address
//   mem_we_o         out  1    memory write enable
//   mem_be_o         out  DW/8 memory byte enables
//   mem_wdata_o      out  DW   memory write data
//   mem_gnt_i        in   1    memory accepted request
//   mem_rvalid_i     in   1    memory response valid (in order)
//   mem_rdata_i      in   DW   memory read data
//   mem_err_i        in   1    memory error
//   outstanding_o    out  clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
//   protocol_err_o   out  1    sticky protocol violation flag
// BEHAVIOUR
//   Reset: FSM=IDLE, FIFO empty, outstanding_o=0, protocol_err_o=0, last winner=INSTR (data wins first tie);
//     all gnt/rvalid/err outputs and mem_req_o 0 combinationally whenever FIFO/inputs idle.
//   FSM {IDLE, HOLD_I, HOLD_D}. IDLE: winner picked combinationally from requests; tie -> port not granted
//     last (FIXED_PRIO=1: DATA). Winner drives mem_* same cycle. Winner ungranted -> HOLD_x.
//   HOLD_x: selection frozen on port x, other port gets no grant; mem_gnt_i -> IDLE. If x drops req in HOLD_x
//     -> IDLE, protocol_err_o<=1, nothing pushed.
//   Grant pass-through: x_gnt_o = mem_req_o & mem_gnt_i & sel==x (zero added latency); last winner <= x.
//   Instr selected: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0. No request: mem_* address/data = 0.
//   FIFO holds 1-bit source ID; push on mem_req_o&mem_gnt_i, pop on mem_rvalid_i; push+pop same cycle legal
//     (occupancy unchanged, also when full).
//   FIFO full and no pop this cycle: mem_req_o=0, no grants, FSM state held.
//   Response: x_rvalid_o = mem_rvalid_i & head==x, same cycle; rdata_o of both ports = mem_rdata_i;
//     data_err_o = mem_err_i & head==DATA; mem_err_i on an instr response -> protocol_err_o<=1.
//   mem_rvalid_i with FIFO empty: dropped, no rvalid out, protocol_err_o<=1.
//   Reset mid-operation: FIFO cleared; responses to pre-reset grants are dropped and flag protocol_err_o
//     (system resets memory together with arbiter). protocol_err_o cleared only by reset.
// TESTING
//   instr-only, addr 0x20, mem_gnt_i=1, rvalid 1 cycle later rdata 0xDEADBEEF -> instr_gnt_o same cycle,
//     instr_rvalid_o next cycle with 0xDEADBEEF, outstanding_o 1->0.
//   both req every cycle, mem_gnt_i=1 -> grants alternate D,I,D,I from reset; FIXED_PRIO=1 -> D always.
//   data write 0x100 be=4'b0011 held 3 cycles with mem_gnt_i=0 while instr req -> mem_addr_o stays 0x100,
//     instr_gnt_o=0 throughout, instr granted cycle after data grant.
//   MAX_OUTSTANDING=2, rvalid withheld -> third request stalls with mem_req_o=0; rvalid+new grant same cycle
//     -> outstanding_o stays 2.
//   grants I,D,I then 3 rvalids with mem_err_i on 2nd -> instr,data(err=1),instr routed in order, err flag 0.
//   spurious mem_rvalid_i at reset-empty FIFO -> no rvalid outputs, protocol_err_o=1 until rst_i.

Source files
------------

// File: rtl/ryuki_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one req/gnt/rvalid memory port.
// Responses return in order and are routed by a small FIFO of source IDs.
module ryuki_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter bit FIXED_PRIO      = 1'b0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 instr_req_i,
   input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
   output logic                                 instr_gnt_o,
   output logic                                 instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]                instr_rdata_o,
   input  logic                                 data_req_i,
   input  logic [ADDR_WIDTH-1:0]                data_addr_i,
   input  logic                                 data_we_i,
   input  logic [DATA_WIDTH/8-1:0]              data_be_i,
   input  logic [DATA_WIDTH-1:0]                data_wdata_i,
   output logic                                 data_gnt_o,
   output logic                                 data_rvalid_o,
   output logic [DATA_WIDTH-1:0]                data_rdata_o,
   output logic                                 data_err_o,
   output logic                                 mem_req_o,
   output logic [ADDR_WIDTH-1:0]                mem_addr_o,
   output logic                                 mem_we_o,
   output logic [DATA_WIDTH/8-1:0]              mem_be_o,
   output logic [DATA_WIDTH-1:0]                mem_wdata_o,
   input  logic                                 mem_gnt_i,
   input  logic                                 mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
   input  logic                                 mem_err_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 protocol_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int BE_W  = DATA_WIDTH / 8;

   // Handshake: a request is accepted in the cycle where mem_req_o and mem_gnt_i
   // are both high; once offered, the selected port must hold its request until then.
   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;

   state_e                     state_q, state_d;
   logic                       last_q, last_d;      // 1 = data port won last
   logic                       perr_q, perr_d;
   logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;      // source IDs, 1 = data
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;

   logic sel_data, sel_valid, stall, grant, pop, empty, full, head;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      perr_d    = perr_q;
      fifo_d    = fifo_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      sel_data  = 1'b0;
      sel_valid = 1'b0;

      empty = (count_q == '0);
      full  = (count_q == CNT_W'(MAX_OUTSTANDING));
      head  = fifo_q[rd_ptr_q];
      pop   = mem_rvalid_i & ~empty;
      stall = full & ~pop;

      case (state_q)
         HOLD_I: begin
            sel_data  = 1'b0;
            sel_valid = instr_req_i;
         end
         HOLD_D: begin
            sel_data  = 1'b1;
            sel_valid = data_req_i;
         end
         default: begin
            if (instr_req_i && data_req_i)
               sel_data = FIXED_PRIO ? 1'b1 : ~last_q;
            else
               sel_data = data_req_i;
            sel_valid = instr_req_i | data_req_i;
         end
      endcase

      mem_req_o = sel_valid & ~stall;
      grant     = mem_req_o & mem_gnt_i;

      if ((state_q != IDLE) && !sel_valid) begin
         state_d = IDLE;
         perr_d  = 1'b1;
      end else if (grant) begin
         state_d = IDLE;
         last_d  = sel_data;
      end else if (mem_req_o) begin
         state_d = sel_data ? HOLD_D : HOLD_I;
      end

      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (mem_req_o) begin
         if (sel_data) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_addr_o = instr_addr_i;
            mem_be_o   = {BE_W{1'b1}};
         end
      end

      instr_gnt_o    = grant & ~sel_data;
      data_gnt_o     = grant & sel_data;
      instr_rvalid_o = pop & ~head;
      data_rvalid_o  = pop & head;
      data_err_o     = data_rvalid_o & mem_err_i;
      instr_rdata_o  = mem_rdata_i;
      data_rdata_o   = mem_rdata_i;

      // Orphan responses and errors on instruction fetches are both reported.
      if (mem_rvalid_i && empty) perr_d = 1'b1;
      if (instr_rvalid_o && mem_err_i) perr_d = 1'b1;

      if (grant) begin
         fifo_d[wr_ptr_q] = sel_data;
         wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({grant, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      outstanding_o  = count_q;
      protocol_err_o = perr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         last_q   <= 1'b0;
         perr_q   <= 1'b0;
         fifo_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         perr_q   <= perr_d;
         fifo_q   <= fifo_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_ryuki_mem_arbiter.sv
// Directed bench for ryuki_mem_arbiter: a round-robin instance plus a
// data-first instance sharing the same stimulus.
module tb_ryuki_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
   logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
   logic [3:0]  data_be;

   logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err;
   logic        mem_req, mem_we, perr;
   logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [1:0]  outstanding;

   logic        f_instr_gnt, f_instr_rvalid, f_data_gnt, f_data_rvalid, f_data_err;
   logic        f_mem_req, f_mem_we, f_perr;
   logic [31:0] f_instr_rdata, f_data_rdata, f_mem_addr, f_mem_wdata;
   logic [3:0]  f_mem_be;
   logic [1:0]  f_outstanding;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ryuki_mem_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
      .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
      .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(outstanding), .protocol_err_o(perr)
   );

   ryuki_mem_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) dut_fix (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(f_instr_gnt),
      .instr_rvalid_o(f_instr_rvalid), .instr_rdata_o(f_instr_rdata),
      .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
      .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(f_data_gnt),
      .data_rvalid_o(f_data_rvalid), .data_rdata_o(f_data_rdata), .data_err_o(f_data_err),
      .mem_req_o(f_mem_req), .mem_addr_o(f_mem_addr), .mem_we_o(f_mem_we), .mem_be_o(f_mem_be),
      .mem_wdata_o(f_mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(f_outstanding), .protocol_err_o(f_perr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      instr_req = 1'b0; instr_addr = '0;
      data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_be = '0; data_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_perr", 32'(perr), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_gnts", {30'd0, instr_gnt, data_gnt}, 0);
      chk("rst_rvalids", {30'd0, instr_rvalid, data_rvalid}, 0);
      rst = 1'b0;

      // instruction-only read
      tick();
      instr_req = 1'b1; instr_addr = 32'h20; mem_gnt = 1'b1;
      #1;
      chk("i_only_mem_req", 32'(mem_req), 1);
      chk("i_only_addr", mem_addr, 32'h20);
      chk("i_only_be", 32'(mem_be), 32'hF);
      chk("i_only_we", 32'(mem_we), 0);
      chk("i_only_gnt", {30'd0, instr_gnt, data_gnt}, 32'b10);
      tick();
      instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("i_only_outst1", 32'(outstanding), 1);
      chk("i_only_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'b10);
      chk("i_only_rdata", instr_rdata, 32'hDEADBEEF);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("i_only_outst0", 32'(outstanding), 0);

      // both request every cycle: D,I,D,I; data-first instance always D
      instr_req = 1'b1; instr_addr = 32'h44;
      data_req = 1'b1; data_addr = 32'h40; mem_gnt = 1'b1;
      #1;
      chk("rr0_gnt", {30'd0, instr_gnt, data_gnt}, 32'b01);
      chk("fix0_gnt", {30'd0, f_instr_gnt, f_data_gnt}, 32'b01);
      tick();
      mem_rvalid = 1'b1;
      #1;
      chk("rr1_gnt", {30'd0, instr_gnt, data_gnt}, 32'b10);
      chk("rr1_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'b01);
      chk("fix1_gnt", {30'd0, f_instr_gnt, f_data_gnt}, 32'b01);
      tick();
      chk("rr2_gnt", {30'd0, instr_gnt, data_gnt}, 32'b01);
      chk("rr2_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'b10);
      chk("fix2_gnt", {30'd0, f_instr_gnt, f_data_gnt}, 32'b01);
      tick();
      chk("rr3_gnt", {30'd0, instr_gnt, data_gnt}, 32'b10);
      chk("fix3_gnt", {30'd0, f_instr_gnt, f_data_gnt}, 32'b01);
      tick();
      instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
      #1;
      chk("rr_drain_outst", 32'(outstanding), 1);
      chk("rr_drain_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'b10);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("rr_empty", 32'(outstanding), 0);
      chk("rr_perr", 32'(perr), 0);

      // data write held without grant while instr waits
      data_req = 1'b1; data_addr = 32'h100; data_we = 1'b1; data_be = 4'b0011;
      data_wdata = 32'h1234_5678; instr_req = 1'b1; instr_addr = 32'h80;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_addr", mem_addr, 32'h100);
         chk("hold_we_be", {27'd0, mem_we, mem_be}, {27'd0, 1'b1, 4'b0011});
         chk("hold_wdata", mem_wdata, 32'h1234_5678);
         chk("hold_gnts", {30'd0, instr_gnt, data_gnt}, 0);
         tick();
      end
      mem_gnt = 1'b1;
      #1;
      chk("hold_dgnt", {30'd0, instr_gnt, data_gnt}, 32'b01);
      tick();
      data_req = 1'b0; data_we = 1'b0; data_be = '0;
      #1;
      chk("hold_igntnext", {30'd0, instr_gnt, data_gnt}, 32'b10);
      chk("hold_iaddr", mem_addr, 32'h80);

      // FIFO full: stall, then pop with simultaneous grant
      tick();
      instr_addr = 32'h90;
      #1;
      chk("full_outst", 32'(outstanding), 2);
      chk("full_mem_req", 32'(mem_req), 0);
      chk("full_igntless", 32'(instr_gnt), 0);
      tick();
      chk("full_still_stall", 32'(mem_req), 0);
      mem_rvalid = 1'b1;
      #1;
      chk("full_pop_dvalid", {30'd0, instr_rvalid, data_rvalid}, 32'b01);
      chk("full_pop_gnt", 32'(instr_gnt), 1);
      tick();
      instr_req = 1'b0;
      #1;
      chk("full_outst_kept", 32'(outstanding), 2);
      chk("full_drain1", {30'd0, instr_rvalid, data_rvalid}, 32'b10);
      tick();
      chk("full_drain2", {30'd0, instr_rvalid, data_rvalid}, 32'b10);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("full_empty", 32'(outstanding), 0);

      // in-order routing I,D,I with error on the data response
      instr_req = 1'b1; instr_addr = 32'hA0;
      #1;
      chk("ord_g1", {30'd0, instr_gnt, data_gnt}, 32'b10);
      tick();
      instr_req = 1'b0; data_req = 1'b1; data_addr = 32'hB0;
      #1;
      chk("ord_g2", {30'd0, instr_gnt, data_gnt}, 32'b01);
      tick();
      data_req = 1'b0; instr_req = 1'b1; instr_addr = 32'hC0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      #1;
      chk("ord_g3", {30'd0, instr_gnt, data_gnt}, 32'b10);
      chk("ord_r1", {30'd0, instr_rvalid, data_rvalid}, 32'b10);
      chk("ord_r1_data", instr_rdata, 32'h1111_1111);
      tick();
      instr_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b1; mem_rdata = 32'h2222_2222;
      #1;
      chk("ord_r2", {29'd0, instr_rvalid, data_rvalid, data_err}, 32'b011);
      chk("ord_r2_data", data_rdata, 32'h2222_2222);
      tick();
      mem_err = 1'b0; mem_rdata = 32'h3333_3333;
      #1;
      chk("ord_r3", {29'd0, instr_rvalid, data_rvalid, data_err}, 32'b100);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("ord_perr", 32'(perr), 0);
      chk("ord_empty", 32'(outstanding), 0);

      // spurious response with empty FIFO
      mem_rvalid = 1'b1;
      #1;
      chk("spur_rvalids", {30'd0, instr_rvalid, data_rvalid}, 0);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("spur_perr", 32'(perr), 1);
      tick();
      tick();
      chk("spur_sticky", 32'(perr), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("spur_cleared", 32'(perr), 0);

      // request dropped while held
      data_req = 1'b1; data_addr = 32'h200;
      tick();
      data_req = 1'b0;
      #1;
      chk("drop_mem_req", 32'(mem_req), 0);
      tick();
      chk("drop_perr", 32'(perr), 1);
      chk("drop_outst", 32'(outstanding), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
